// File: rtl/led_state_seg7.sv
// Traffic-light lamp and seven-segment countdown driver; all outputs registered, one cycle of latency.
// Optional macro YELLOW_BLINK_EN makes the yellow lamp blink on alternate cycles instead of staying steady.
module led_state_seg7 #(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] state,
   input  logic [3:0] iDIG,
   output logic       LEDG,
   output logic [1:0] LEDR,
   output logic [6:0] oSEG
);

   typedef enum logic [1:0] {
      GREEN   = 2'd0,
      YELLOW  = 2'd1,
      RED     = 2'd2,
      ILLEGAL = 2'd3
   } light_t;

   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

   light_t     light;
   logic [6:0] seg_pat;
   logic [6:0] seg_next;
   logic       ledg_next;
   logic [1:0] ledr_next;
   logic       yellow_on;

   assign light = light_t'(state);

   // Active-low pattern, bit 6 = g down to bit 0 = a.
   always_comb begin
      seg_pat = 7'b1111111;
      case (iDIG)
         4'h0: seg_pat = 7'b1000000;
         4'h1: seg_pat = 7'b1111001;
         4'h2: seg_pat = 7'b0100100;
         4'h3: seg_pat = 7'b0110000;
         4'h4: seg_pat = 7'b0011001;
         4'h5: seg_pat = 7'b0010010;
         4'h6: seg_pat = 7'b0000010;
         4'h7: seg_pat = 7'b1111000;
         4'h8: seg_pat = 7'b0000000;
         4'h9: seg_pat = 7'b0011000;
         4'hA: seg_pat = 7'b0001000;
         4'hB: seg_pat = 7'b0000011;
         4'hC: seg_pat = 7'b1000110;
         4'hD: seg_pat = 7'b0100001;
         4'hE: seg_pat = 7'b0000110;
         4'hF: seg_pat = 7'b0001110;
         default: seg_pat = 7'b1111111;
      endcase
   end

   assign seg_next = SEG_ACTIVE_LOW ? seg_pat : ~seg_pat;

`ifdef YELLOW_BLINK_EN
   logic phase;

   // Phase is 0 on every YELLOW entry, so the first yellow cycle is lit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 phase <= 1'b0;
      else if (light == YELLOW) phase <= ~phase;
      else                     phase <= 1'b0;
   end

   assign yellow_on = ~phase;
`else
   assign yellow_on = 1'b1;
`endif

   // Illegal state falls back to red so a corrupted input never shows green.
   always_comb begin
      ledg_next = 1'b0;
      ledr_next = 2'b01;
      case (light)
         GREEN:   begin ledg_next = 1'b1; ledr_next = 2'b00; end
         YELLOW:  begin ledg_next = 1'b0; ledr_next = {yellow_on, 1'b0}; end
         RED:     begin ledg_next = 1'b0; ledr_next = 2'b01; end
         default: begin ledg_next = 1'b0; ledr_next = 2'b01; end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         LEDG <= 1'b0;
         LEDR <= 2'b00;
         oSEG <= SEG_OFF;
      end else begin
         LEDG <= ledg_next;
         LEDR <= ledr_next;
         oSEG <= seg_next;
      end
   end

endmodule

// File: tb/tb_led_state_seg7.sv
// Scoreboard bench for led_state_seg7: active-low and active-high instances share all stimulus.
// Driver pushes expectations at the negedge; a monitor pops and compares 2 time units after each posedge.
module tb_led_state_seg7;

   logic       clk;
   logic       rst;
   logic [1:0] state;
   logic [3:0] iDIG;
   logic       ledg_l, ledg_h;
   logic [1:0] ledr_l, ledr_h;
   logic [6:0] seg_l, seg_h;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic       ledg;
      logic [1:0] ledr;
      logic [6:0] seg;
   } exp_t;

   exp_t q[$];
   logic ph;

   // Hand-copied active-low table, g..a.
   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   led_state_seg7 #(.SEG_ACTIVE_LOW(1'b1)) dut_l (
      .clk(clk), .rst(rst), .state(state), .iDIG(iDIG),
      .LEDG(ledg_l), .LEDR(ledr_l), .oSEG(seg_l));

   led_state_seg7 #(.SEG_ACTIVE_LOW(1'b0)) dut_h (
      .clk(clk), .rst(rst), .state(state), .iDIG(iDIG),
      .LEDG(ledg_h), .LEDR(ledr_h), .oSEG(seg_h));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [1:0] s, input logic [3:0] d);
      exp_t e;
      @(negedge clk);
      rst   = 1'b0;
      state = s;
      iDIG  = d;
      e.seg = seg_tab[d];
      case (s)
         2'd0: begin e.ledg = 1'b1; e.ledr = 2'b00; ph = 1'b0; end
         2'd1: begin
            e.ledg = 1'b0;
`ifdef YELLOW_BLINK_EN
            ph     = ~ph;
            e.ledr = {ph, 1'b0};
`else
            e.ledr = 2'b10;
`endif
         end
         default: begin e.ledg = 1'b0; e.ledr = 2'b01; ph = 1'b0; end
      endcase
      q.push_back(e);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ledg_l"}, {7'd0, ledg_l}, 8'd0);
      chk({tag, "_ledr_l"}, {6'd0, ledr_l}, 8'd0);
      chk({tag, "_seg_l"},  {1'b0, seg_l},  8'h7F);
      chk({tag, "_ledg_h"}, {7'd0, ledg_h}, 8'd0);
      chk({tag, "_ledr_h"}, {6'd0, ledr_h}, 8'd0);
      chk({tag, "_seg_h"},  {1'b0, seg_h},  8'h00);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #2;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("ledg_l", {7'd0, ledg_l}, {7'd0, e.ledg});
         chk("ledr_l", {6'd0, ledr_l}, {6'd0, e.ledr});
         chk("seg_l",  {1'b0, seg_l},  {1'b0, e.seg});
         chk("ledg_h", {7'd0, ledg_h}, {7'd0, e.ledg});
         chk("ledr_h", {6'd0, ledr_h}, {6'd0, e.ledr});
         chk("seg_h",  {1'b0, seg_h},  {1'b0, ~e.seg});
         chk("no_green_red", {7'd0, ledg_l & ledr_l[0]}, 8'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ph    = 1'b0;
      rst   = 1'b1;
      state = 2'd0;
      iDIG  = 4'd5;
      repeat (2) @(negedge clk);
      chk_reset("por");

      step(2'd0, 4'd5);
      for (int i = 0; i < 16; i++) step(2'd2, 4'(i));
      step(2'd0, 4'd3);
      step(2'd1, 4'd3);
      step(2'd2, 4'd3);
      step(2'd0, 4'd3);
      step(2'd3, 4'd9);
      for (int i = 0; i < 4; i++) step(2'd1, 4'd7);
      step(2'd2, 4'd6);
      step(2'd1, 4'd8);
      step(2'd1, 4'd8);

      // Mid-cycle reset while yellow, with iDIG = 8 lighting every segment.
      @(posedge clk);
      #5;
      chk("pre_rst_seg_h", {1'b0, seg_h}, 8'h7F);
      rst = 1'b1;
      ph  = 1'b0;
      #1;
      chk_reset("async");
      @(posedge clk);
      #2;
      chk_reset("held");
      step(2'd1, 4'd10);
      step(2'd0, 4'd15);

      repeat (3) @(posedge clk);
      #5;
      chk("queue_drained", 8'(q.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/led_state_seg7.md
LED_STATE_SEG7 -- requirements
Module: led_state_seg7

Interface
REQ-001 Reset is asynchronous and active-high; single clock clk; all registers clocked on rising edge of clk.
REQ-002 Parameter: SEG_ACTIVE_LOW, default 1, 1 = segment lit when bit is 0, 0 = segment lit when bit is 1.
REQ-003 clk  input  1  system clock (1 Hz tick domain of the traffic controller).
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 state  input  2  light state: 0 = GREEN, 1 = YELLOW, 2 = RED, 3 = illegal.
REQ-006 iDIG  input  4  binary digit to display (seconds remaining), 0..15.
REQ-007 LEDG  output  1  green lamp, 1 = on.
REQ-008 LEDR  output  2  LEDR[1] = yellow lamp, LEDR[0] = red lamp, 1 = on.
REQ-009 oSEG  output  7  seven-segment drive, oSEG[0..6] = segments a..g.

Function
REQ-010 All outputs registered; outputs reflect state/iDIG sampled at the previous rising clk edge (latency 1 cycle).
REQ-011 state 0: LEDG = 1, LEDR = 2'b00.
REQ-012 state 1: LEDG = 0, LEDR = 2'b10 (steady unless YELLOW_BLINK_EN, REQ-020).
REQ-013 state 2: LEDG = 0, LEDR = 2'b01.
REQ-014 state 3 (illegal): fail-safe red, LEDG = 0, LEDR = 2'b01.
REQ-015 At most one lamp on in any cycle; no cycle with green and red both on, including on a state change.
REQ-016 Segment table (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-017 With SEG_ACTIVE_LOW = 0, oSEG is the bitwise inverse of the REQ-016 pattern.
REQ-018 Segment decode and lamp decode are independent; a change of iDIG and state on the same edge updates both outputs on that edge.

Reset
REQ-019 While rst = 1: LEDG = 0, LEDR = 2'b00, oSEG = all segments off (7'b1111111 when active-low, 7'b0000000 otherwise), blink phase = 0. Outputs update on the first rising clk edge after rst deasserts. Reset asserted mid-operation clears outputs immediately without waiting for clk.

Configuration
REQ-020 Macro YELLOW_BLINK_EN: when defined, an internal blink-phase flop toggles on every clk edge while state = 1 and LEDR[1] = phase (first YELLOW cycle on, then off, alternating); the phase is cleared to 0 whenever state != 1, so every YELLOW entry starts lit. When undefined, there is no phase flop and yellow is steady per REQ-012.

Verification
REQ-021 rst = 1 with state = 0, iDIG = 5 -> LEDG = 0, LEDR = 00, oSEG = 1111111; release rst, one clk -> LEDG = 1, oSEG = 0010010.
REQ-022 Sweep iDIG 0..15 with state = 2 -> oSEG matches REQ-016 one cycle later; LEDR = 01 throughout.
REQ-023 state sequence 0,1,2,0 on consecutive clks -> (LEDG, LEDR) = (1,00), (0,10), (0,01), (1,00) with 1-cycle latency; never green and red together.
REQ-024 state = 3 -> LEDG = 0, LEDR = 01 on next clk.
REQ-025 With YELLOW_BLINK_EN, state held at 1 for 4 clks -> LEDR[1] = 1,0,1,0; leave to 2, re-enter 1 -> LEDR[1] = 1 first cycle. Without the macro -> LEDR[1] = 1,1,1,1.
REQ-026 Assert rst asynchronously between clk edges while state = 1 -> outputs go to reset values before the next edge; SEG_ACTIVE_LOW = 0 build, iDIG = 8 -> oSEG = 1111111.
